// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmitter: bus window, register offsets,
// TX state encoding and reset divisor.
package uart_tx_pkg;

    localparam logic [31:0] UART_ADDR_L = 32'h0000_FF40;
    localparam logic [31:0] UART_ADDR_R = 32'h0000_FF4F;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int UART_DIV_RESET = 434;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with a separate occupancy counter; pushes when full and
// pops when empty are ignored.
module uart_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, byte FIFO, baud
// counter and TX state machine.
import uart_tx_pkg::*;

module uart_tx #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_RESET  = UART_DIV_RESET
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        rw,
    input  logic [31:0] addr,
    output logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic        UART_TXD
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t     state, state_nxt;
    logic [15:0]   bcnt, bcnt_nxt;
    logic [2:0]    bitn, bitn_nxt;
    logic [7:0]    shift, shift_nxt;
    logic [15:0]   div;
    logic          overflow;
    logic          txd;
    logic          pop;

    logic          wr_en;
    logic          data_wr;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;
    logic          unused_bits;

    assign wr_en       = ena & rw;
    assign data_wr     = wr_en && (addr[3:2] == REG_DATA);
    assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:16]};

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (data_wr),
        .wdata (wdata[7:0]),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div      <= 16'(DIV_RESET);
            overflow <= 1'b0;
        end else begin
            if (wr_en && (addr[3:2] == REG_DIV))
                div <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
            if (wr_en && (addr[3:2] == REG_STATUS))
                overflow <= 1'b0;
            else if (data_wr && fifo_full)
                overflow <= 1'b1;
        end
    end

    always_comb begin
        status         = '0;
        status[0]      = (state != ST_IDLE);
        status[1]      = fifo_full;
        status[2]      = fifo_empty;
        status[3]      = overflow;
        status[4 +: CW] = fifo_count;
        rdata          = '0;
        case (addr[3:2])
            REG_STATUS: rdata = status;
            REG_DIV:    rdata = {16'h0000, div};
            default:    ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            bcnt  <= '0;
            bitn  <= '0;
            shift <= '0;
        end else begin
            state <= state_nxt;
            bcnt  <= bcnt_nxt;
            bitn  <= bitn_nxt;
            shift <= shift_nxt;
        end
    end

    // bcnt reloads from the live divisor, so a new DIV applies at the next bit boundary
    always_comb begin
        state_nxt = state;
        bcnt_nxt  = bcnt;
        bitn_nxt  = bitn;
        shift_nxt = shift;
        pop       = 1'b0;
        txd       = 1'b1;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_nxt = fifo_rdata;
                    bcnt_nxt  = div - 16'd1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                txd = 1'b0;
                if (bcnt == 16'd0) begin
                    bcnt_nxt  = div - 16'd1;
                    bitn_nxt  = '0;
                    state_nxt = ST_DATA;
                end else begin
                    bcnt_nxt = bcnt - 16'd1;
                end
            end
            ST_DATA: begin
                txd = shift[0];
                if (bcnt == 16'd0) begin
                    bcnt_nxt  = div - 16'd1;
                    shift_nxt = {1'b0, shift[7:1]};
                    if (bitn == 3'd7)
                        state_nxt = ST_STOP;
                    else
                        bitn_nxt = bitn + 3'd1;
                end else begin
                    bcnt_nxt = bcnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (bcnt == 16'd0)
                    state_nxt = ST_IDLE;
                else
                    bcnt_nxt = bcnt - 16'd1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // TX line decodes from registered state, so reset forces it high without a clock
    assign UART_TXD = txd;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: bus register checks, cycle-exact frame
// checks, and a serial monitor matched against a byte scoreboard.
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        UART_TXD;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  sb[$];
    int unsigned cur_div = 434;
    bit          mon_en  = 1'b1;

    uart_tx #(
        .FIFO_DEPTH (8),
        .DIV_RESET  (434)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .rw       (rw),
        .addr     (addr),
        .rdata    (rdata),
        .wdata    (wdata),
        .UART_TXD (UART_TXD)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Serial monitor: decodes frames at the current divisor and checks them against the scoreboard
    initial begin : monitor
        logic [7:0]  got;
        logic [7:0]  exp;
        int unsigned d;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (mon_en && !rst && UART_TXD === 1'b0) begin
                d       = cur_div;
                aborted = 1'b0;
                got     = '0;
                for (int i = 0; i < 9 && !aborted; i++) begin
                    repeat (d) @(negedge clk);
                    if (rst)
                        aborted = 1'b1;
                    else if (i < 8)
                        got[i] = UART_TXD;
                    else begin
                        total++;
                        if (UART_TXD !== 1'b1) begin
                            bad++;
                            $display("FAIL stop_bit: got %b expected 1", UART_TXD);
                        end
                    end
                end
                if (!aborted) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_frame: got %02h expected none", got);
                    end else begin
                        exp = sb.pop_front();
                        if (got !== exp) begin
                            bad++;
                            $display("FAIL frame_byte: got %02h expected %02h", got, exp);
                        end
                    end
                end
            end
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        ena   = 1'b1;
        rw    = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        ena  = 1'b0;
        rw   = 1'b0;
        addr = 32'h4;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            @(posedge clk);
            n++;
        end
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d bytes pending expected 0", sb.size());
        end
    endtask

    task automatic test_reset;
        logic [31:0] v;
        rst   = 1'b1;
        ena   = 1'b0;
        rw    = 1'b0;
        addr  = 32'h4;
        wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (UART_TXD !== 1'b1) begin
            bad++;
            $display("FAIL reset_txd: got %b expected 1", UART_TXD);
        end
        rst = 1'b0;
        bus_read(32'h4, v);
        total++;
        if (v !== 32'h0000_0004) begin
            bad++;
            $display("FAIL reset_status: got %08h expected 00000004", v);
        end
        bus_read(32'h8, v);
        total++;
        if (v !== 32'd434) begin
            bad++;
            $display("FAIL reset_div: got %08h expected %08h", v, 32'd434);
        end
        bus_read(32'h0, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL reset_data_read: got %08h expected 00000000", v);
        end
    endtask

    task automatic test_single_frame;
        logic [31:0] st;
        logic [7:0]  pat;
        logic        et;
        pat = 8'h55;
        bus_write(32'h8, 32'd4);
        cur_div = 4;
        bus_write(32'h0, {24'h0, pat});
        sb.push_back(pat);
        bus_read(32'h4, st);
        total++;
        if (st !== 32'h0000_0010) begin
            bad++;
            $display("FAIL status_after_push: got %08h expected 00000010", st);
        end
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            bus_read(32'h4, st);
            if (c < 4)       et = 1'b0;
            else if (c < 36) et = pat[(c - 4) / 4];
            else             et = 1'b1;
            total++;
            if (UART_TXD !== et) begin
                bad++;
                $display("FAIL wave_c%0d: got %b expected %b", c, UART_TXD, et);
            end
            total++;
            if (st[0] !== 1'b1) begin
                bad++;
                $display("FAIL busy_c%0d: got %b expected 1", c, st[0]);
            end
        end
        @(posedge clk);
        #1;
        bus_read(32'h4, st);
        total++;
        if (st !== 32'h0000_0004 || UART_TXD !== 1'b1) begin
            bad++;
            $display("FAIL frame_end: got status %08h txd %b expected 00000004 txd 1", st, UART_TXD);
        end
        wait_drain(20);
    endtask

    task automatic test_back_to_back;
        logic [31:0] st;
        bus_write(32'h8, 32'd2);
        cur_div = 2;
        for (int i = 0; i < 9; i++) begin
            bus_write(32'h0, 32'(i));
            sb.push_back(8'(i));
        end
        bus_read(32'h4, st);
        total++;
        if (st !== 32'h0000_0083) begin
            bad++;
            $display("FAIL full_status: got %08h expected 00000083", st);
        end
        bus_write(32'h0, 32'h09);
        bus_read(32'h4, st);
        total++;
        if (st !== 32'h0000_008B) begin
            bad++;
            $display("FAIL overflow_set: got %08h expected 0000008b", st);
        end
        bus_write(32'h4, 32'h0);
        bus_read(32'h4, st);
        total++;
        if (st !== 32'h0000_0083) begin
            bad++;
            $display("FAIL overflow_clear: got %08h expected 00000083", st);
        end
        wait_drain(400);
        repeat (40) @(posedge clk);
        #1;
        bus_read(32'h4, st);
        total++;
        if (st !== 32'h0000_0004) begin
            bad++;
            $display("FAIL b2b_idle_status: got %08h expected 00000004", st);
        end
    endtask

    task automatic test_div_zero;
        logic [31:0] v;
        int          n;
        bus_write(32'h8, 32'd0);
        bus_read(32'h8, v);
        total++;
        if (v !== 32'd1) begin
            bad++;
            $display("FAIL div_zero_read: got %08h expected 00000001", v);
        end
        cur_div = 1;
        bus_write(32'h0, 32'hA3);
        sb.push_back(8'hA3);
        n = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            bus_read(32'h4, v);
            if (v[0] === 1'b1)
                n++;
            else if (n > 0)
                break;
        end
        total++;
        if (n != 10) begin
            bad++;
            $display("FAIL div1_frame_len: got %0d cycles expected 10", n);
        end
        wait_drain(20);
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] v;
        int          lows;
        mon_en = 1'b0;
        bus_write(32'h8, 32'd4);
        cur_div = 4;
        bus_write(32'h0, 32'h11);
        bus_write(32'h0, 32'h22);
        bus_write(32'h0, 32'h33);
        repeat (16) @(posedge clk);
        #2;
        total++;
        if (UART_TXD !== 1'b0) begin
            bad++;
            $display("FAIL bit3_level: got %b expected 0", UART_TXD);
        end
        rst = 1'b1;
        #1;
        total++;
        if (UART_TXD !== 1'b1) begin
            bad++;
            $display("FAIL async_reset_txd: got %b expected 1", UART_TXD);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cur_div = 434;
        bus_read(32'h4, v);
        total++;
        if (v !== 32'h0000_0004) begin
            bad++;
            $display("FAIL post_reset_status: got %08h expected 00000004", v);
        end
        bus_read(32'h8, v);
        total++;
        if (v !== 32'd434) begin
            bad++;
            $display("FAIL post_reset_div: got %08h expected %08h", v, 32'd434);
        end
        lows = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (UART_TXD !== 1'b1)
                lows++;
        end
        total++;
        if (lows != 0) begin
            bad++;
            $display("FAIL discarded_queue: got %0d low cycles expected 0", lows);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_reserved;
        logic [31:0] v;
        int          lows;
        bus_write(32'h8, 32'hFFFF_0009);
        bus_read(32'h8, v);
        total++;
        if (v !== 32'h0000_0009) begin
            bad++;
            $display("FAIL div_upper_bits: got %08h expected 00000009", v);
        end
        bus_write(32'h8, 32'd7);
        cur_div = 7;
        bus_read(32'hC, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL rsvd_read: got %08h expected 00000000", v);
        end
        bus_read(32'h0, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL data_read: got %08h expected 00000000", v);
        end
        bus_write(32'hC, 32'h0000_00A5);
        bus_read(32'h8, v);
        total++;
        if (v !== 32'd7) begin
            bad++;
            $display("FAIL rsvd_write_div: got %08h expected 00000007", v);
        end
        bus_read(32'h4, v);
        total++;
        if (v !== 32'h0000_0004) begin
            bad++;
            $display("FAIL rsvd_write_status: got %08h expected 00000004", v);
        end
        lows = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (UART_TXD !== 1'b1)
                lows++;
        end
        total++;
        if (lows != 0) begin
            bad++;
            $display("FAIL rsvd_write_tx: got %0d low cycles expected 0", lows);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_div_zero();
        test_reset_mid_frame();
        test_reserved();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got %0d expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
